quad_gen: RTL and testbench
===========================

# quad_gen

Quadrature signal generator: drives an A/B pulse pair stepping an internal position toward a commanded target at a programmable rate, one quadrature edge per step. It is the transmit side of the quadrature interface our `quad` decoder receives. It is used to exercise the decoder, debouncers and display path in loopback, and to emit step/direction-equivalent quadrature to external drivers. Position width matches the decoder's 13-bit count.

## Interface
- `COUNT_WIDTH`, 13, width of position and target
- `PERIOD_WIDTH`, 16, width of the step-period register (clocks per quadrature edge)

- `Clk`  input  1  system clock; all logic on rising edge
- `rst`  input  1  synchronous reset, active-high
- `i_Target`  input  COUNT_WIDTH  target position, unsigned; sampled when `i_Load`=1
- `i_Period`  input  PERIOD_WIDTH  clocks between quadrature edges; sampled when `i_Load`=1; 0 treated as 1
- `i_Load`  input  1  single-cycle strobe to latch `i_Target`/`i_Period`
- `o_A`  output  1  quadrature channel A (registered)
- `o_B`  output  1  quadrature channel B (registered)
- `o_Position`  output  COUNT_WIDTH  current position (registered)
- `o_Busy`  output  1  high while in RUN
- `o_Done`  output  1  one-cycle pulse when position reaches target

## Operation
- Registers: `target`, `period`, `timer` (PERIOD_WIDTH), `position`, state {IDLE, RUN}.
- Reset values: `o_A`=0, `o_B`=0, `o_Position`=0, `o_Busy`=0, `o_Done`=0, timer=0, period=1, target=0, state IDLE.
- A/B are a pure registered function of `position[1:0]`: 0→AB=00, 1→10, 2→11, 3→01. Forward (increment) means A leads B. Only one of A/B changes per step.
- Direction per step is an unsigned compare. target > position → +1. target < position → −1. Never wraps through 0/max. Position stays within [0, 2^COUNT_WIDTH−1].
- IDLE, `i_Load`=1:
  - Latch target and period (0→1); timer ← latched period.
  - If new target == position: stay IDLE, pulse `o_Done` next cycle.
  - Else: go to RUN.
- RUN, each cycle:
  - If timer==1: step position one toward target, update A/B, timer ← period.
  - Else: timer ← timer−1.
  - If the step makes position == target: go to IDLE and pulse `o_Done` in the same cycle the final A/B change becomes visible.
- RUN, `i_Load`=1 (retarget):
  - Latch new target and period. Timer is not reloaded; the current interval completes, and the new period applies from the next reload.
  - If new target == current position: go IDLE with `o_Done` pulse and no further step. This overrides any step due in that cycle.
  - Otherwise the direction is re-evaluated at the next step, so reversal is allowed.
- `rst` has priority over everything, including mid-RUN. It returns all registers to reset values in one cycle with no `o_Done`.
- `o_Busy` = (state==RUN), registered.

## Timing
- Load latency: `i_Load` sampled at edge n → `o_Busy`=1 after edge n.
- First A/B edge after edge n+P; subsequent edges every P clocks. P = latched period, minimum 1 (P=1 gives an A/B change every clock).
- N steps take N·P clocks from load. `o_Busy` falls and `o_Done` is high after edge n+N·P, for exactly one cycle.
- A/B and `o_Position` change on the same edge; no combinational path from inputs to outputs.
- A/B edge spacing is at least P clocks, including across a direction reversal.

## Test plan
- Reset: assert `rst` 2 cycles → A=B=0, position 0, Busy 0, Done 0.
- Forward: load target 5, period 4 → AB sequence 10,11,01,00,10 at edges +4,+8,+12,+16,+20. Position ends at 5. Done pulses once at +20; Busy high over (+0,+20).
- Reverse and period 0: from position 5, load target 2, period 0 → position 4,3,2 on three consecutive clocks, AB 00,01,11. Done after the third step.
- Null move: load target equal to current position → Busy stays 0; Done pulses one cycle after load; A/B unchanged.
- Retarget mid-run: load target 10, period 8; after 3 steps load target 1, period 2 → next step (at the remaining 8-clock interval) is −1, then steps every 2 clocks down to 1. Done pulses once; A/B never skips a phase.
- Reset mid-run: `rst` during RUN → next cycle all outputs at reset values, no Done. A subsequent load of target 3 works normally.

Source files
------------

// File: rtl/quad_gen.sv
`default_nettype none
// ============================================================================
// Module   : quad_gen
// Purpose  : Quadrature signal generator. Steps an internal position one count
//            at a time toward a commanded target, emitting one A/B quadrature
//            edge per step at a programmable rate (clocks per edge).
// Ports    : Clk        - system clock, all logic on rising edge
//            rst        - synchronous reset, active-high, highest priority
//            i_Target   - target position (unsigned), latched on i_Load
//            i_Period   - clocks per quadrature edge, latched on i_Load (0 -> 1)
//            i_Load     - single-cycle strobe latching i_Target / i_Period
//            o_A, o_B   - quadrature outputs (registered, A leads B forward)
//            o_Position - current position (registered)
//            o_Busy     - high while stepping toward the target
//            o_Done     - one-cycle pulse when position reaches target
// Revision : 1.0 - initial release
// ============================================================================
module quad_gen #(
  parameter int COUNT_WIDTH  = 13,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic [COUNT_WIDTH-1:0]  i_Target,
  input  logic [PERIOD_WIDTH-1:0] i_Period,
  input  logic                    i_Load,
  output logic                    o_A,
  output logic                    o_B,
  output logic [COUNT_WIDTH-1:0]  o_Position,
  output logic                    o_Busy,
  output logic                    o_Done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              state, state_next;
  logic [COUNT_WIDTH-1:0]  target, target_next;
  logic [PERIOD_WIDTH-1:0] period, period_next;
  logic [PERIOD_WIDTH-1:0] timer, timer_next;
  logic [COUNT_WIDTH-1:0]  pos_next;
  logic                    a_next, b_next, busy_next, done_next;

  // Values seen by the step logic this cycle: a retarget in RUN takes effect
  // immediately for direction and for any reload happening in the same cycle.
  logic [PERIOD_WIDTH-1:0] load_period;
  logic [COUNT_WIDTH-1:0]  eff_target;
  logic [PERIOD_WIDTH-1:0] eff_period;
  logic [COUNT_WIDTH-1:0]  step_pos;
  logic                    null_load;

  assign load_period = (i_Period == '0) ? PERIOD_WIDTH'(1) : i_Period;
  assign eff_target  = i_Load ? i_Target : target;
  assign eff_period  = i_Load ? load_period : period;
  assign null_load   = i_Load && (i_Target == o_Position);

  // Unsigned compare: stepping only ever moves toward the target, so the
  // position can never wrap through 0 or the maximum count.
  always_comb begin
    step_pos = o_Position;
    if (eff_target > o_Position) begin
      step_pos = o_Position + COUNT_WIDTH'(1);
    end else if (eff_target < o_Position) begin
      step_pos = o_Position - COUNT_WIDTH'(1);
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      target     <= '0;
      period     <= PERIOD_WIDTH'(1);
      timer      <= '0;
      o_Position <= '0;
      o_A        <= 1'b0;
      o_B        <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      state      <= state_next;
      target     <= target_next;
      period     <= period_next;
      timer      <= timer_next;
      o_Position <= pos_next;
      o_A        <= a_next;
      o_B        <= b_next;
      o_Busy     <= busy_next;
      o_Done     <= done_next;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_next  = state;
    target_next = target;
    period_next = period;
    timer_next  = timer;
    pos_next    = o_Position;
    case (state)
      ST_IDLE: begin
        if (i_Load) begin
          target_next = i_Target;
          period_next = load_period;
          timer_next  = load_period;
          if (!null_load) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_Load) begin
          target_next = i_Target;
          period_next = load_period;
        end
        if (null_load) begin
          // Retarget onto the current position: stop without stepping.
          state_next = ST_IDLE;
        end else if (timer <= PERIOD_WIDTH'(1)) begin
          pos_next   = step_pos;
          timer_next = eff_period;
          if (step_pos == eff_target) begin
            state_next = ST_IDLE;
          end
        end else begin
          timer_next = timer - PERIOD_WIDTH'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: A/B are the Gray-coded phase of the next position
  // (0->00, 1->10, 2->11, 3->01), so exactly one channel toggles per step.
  always_comb begin
    a_next    = pos_next[1] ^ pos_next[0];
    b_next    = pos_next[1];
    busy_next = (state_next == ST_RUN);
    done_next = ((state == ST_RUN) && (state_next == ST_IDLE)) ||
                ((state == ST_IDLE) && null_load);
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_gen
// Purpose  : Self-checking bench for quad_gen. Loads are converted into a
//            schedule of expected position steps / done pulses (absolute clock
//            edge, position, done flag); a monitor pops the schedule whenever
//            the DUT shows a position change or a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_gen;

  localparam int CW   = 13;
  localparam int PW   = 16;
  localparam int PMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] i_Target = '0;
  logic [PW-1:0] i_Period = '0;
  logic          i_Load = 1'b0;
  logic          o_A, o_B, o_Busy, o_Done;
  logic [CW-1:0] o_Position;

  quad_gen #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
    .Clk(Clk), .rst(rst), .i_Target(i_Target), .i_Period(i_Period),
    .i_Load(i_Load), .o_A(o_A), .o_B(o_B), .o_Position(o_Position),
    .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int t;
    int pos;
    bit done;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  logic rst_q = 1'b0;
  bit   mon_en = 1'b0;
  int   model_pos = 0;
  int   prev_pos = 0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] ab_tab [4];

  initial begin
    ab_tab[0] = 2'b00; ab_tab[1] = 2'b10; ab_tab[2] = 2'b11; ab_tab[3] = 2'b01;
  end

  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge Clk) begin
    if (mon_en) begin
      if (rst_q) begin
        check("reset_outputs", {o_A, o_B, o_Busy, o_Done, o_Position},
              {4'b0000, {CW{1'b0}}});
        prev_pos = 0;
      end else begin
        check("ab_phase", {o_A, o_B}, ab_tab[o_Position[1:0]]);
        if (int'(o_Position) != prev_pos || o_Done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event_pos", int'(o_Position), prev_pos);
            check("unexpected_event_done", int'(o_Done), 0);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_edge", cyc, e.t);
            check("event_pos", int'(o_Position), e.pos);
            check("event_done", int'(o_Done), int'(e.done));
            model_pos = e.pos;
          end
        end else if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
          ev_t e;
          e = exp_q.pop_front();
          check("missed_event_edge", cyc + 1, e.t);
          model_pos = e.pos;
        end
        check("busy", int'(o_Busy), int'(exp_q.size() > 0));
        prev_pos = int'(o_Position);
      end
    end
  end

  // Reference model: a load sampled at edge n reschedules everything from n on.
  // While moving, the next step keeps its already-scheduled time; afterwards
  // steps are spaced by the new period.
  task automatic model_load(input int tgt, input int per);
    int n, p, ts, cur, d, k;
    n = cyc;
    p = (per == 0) ? 1 : per;
    cur = model_pos;
    ts = (exp_q.size() > 0) ? exp_q[0].t : n + p;
    exp_q.delete();
    if (tgt == cur) begin
      exp_q.push_back('{t: n, pos: cur, done: 1'b1});
    end else begin
      d = (tgt > cur) ? 1 : -1;
      k = 0;
      while (cur != tgt) begin
        cur = cur + d;
        exp_q.push_back('{t: ts + k * p, pos: cur, done: (cur == tgt)});
        k++;
      end
    end
  endtask

  task automatic do_load(input int tgt, input int per);
    @(posedge Clk); #2;
    i_Target = tgt[CW-1:0];
    i_Period = per[PW-1:0];
    i_Load   = 1'b1;
    @(posedge Clk); #1;
    i_Load   = 1'b0;
    model_load(tgt, per);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge Clk); #2;
    rst = 1'b1;
    @(posedge Clk); #1;
    exp_q.delete();
    model_pos = 0;
    repeat (ncyc - 1) @(posedge Clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
    check("wait_idle_timeout", int'(exp_q.size() > 0), 0);
    if (exp_q.size() > 0) exp_q.delete();
    @(posedge Clk); #1;
  endtask

  task automatic wait_pos(input int p, input int budget);
    int n;
    n = 0;
    while (model_pos != p && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
    check("wait_pos_timeout", model_pos, p);
  endtask

  initial begin
    int tgt, per;
    repeat (2) @(posedge Clk);
    #1 mon_en = 1'b1;
    @(posedge Clk);
    #1 rst = 1'b0;

    // Forward, reverse with period 0, null move
    do_load(5, 4);    wait_idle(200);
    check("fwd_final_pos", int'(o_Position), 5);
    do_load(2, 0);    wait_idle(200);
    check("rev_final_pos", int'(o_Position), 2);
    do_load(2, 7);    wait_idle(50);

    // Retarget mid-run with reversal
    do_load(10, 8);
    wait_pos(5, 200);
    do_load(1, 2);    wait_idle(400);
    check("retarget_final_pos", int'(o_Position), 1);

    // Reset mid-run, then a normal move
    do_load(20, 3);
    repeat (10) @(posedge Clk);
    do_reset(1);
    do_load(3, 2);    wait_idle(200);
    check("post_reset_pos", int'(o_Position), 3);

    // Boundaries: bottom, full sweep to max, null at max, back off the top
    do_load(0, 1);    wait_idle(100);
    do_load(0, 3);    wait_idle(50);
    do_load(PMAX, 1); wait_idle(PMAX + 100);
    check("max_pos", int'(o_Position), PMAX);
    do_load(PMAX, 0); wait_idle(50);
    do_load(PMAX - 6, 0); wait_idle(100);

    // Random moves, some retargeted mid-flight
    for (int i = 0; i < 60; i++) begin
      tgt = model_pos + int'($urandom_range(0, 40)) - 20;
      if (tgt < 0) tgt = 0;
      if (tgt > PMAX) tgt = PMAX;
      per = int'($urandom_range(0, 5));
      do_load(tgt, per);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 12)) @(posedge Clk);
        tgt = model_pos + int'($urandom_range(0, 30)) - 15;
        if (tgt < 0) tgt = 0;
        if (tgt > PMAX) tgt = PMAX;
        do_load(tgt, int'($urandom_range(0, 4)));
      end
      wait_idle(1000);
    end

    repeat (3) @(posedge Clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
